// File: rtl/sqrt_multi_pkg.sv
// Shared types and elaboration helpers for the multi-bit iterative square-root unit.
package sqrt_multi_pkg;

    localparam int unsigned BITS_PER_ROOT_BIT = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN,
        S_DONE
    } state_t;

    function automatic int unsigned calc_rw(input int unsigned width, input int unsigned frac);
        return width / 2 + frac;
    endfunction

    function automatic int unsigned calc_c(input int unsigned rw, input int unsigned unroll);
        return rw / unroll;
    endfunction

    function automatic int unsigned calc_cnt_w(input int unsigned c);
        return (c <= 1) ? 1 : $clog2(c);
    endfunction

endpackage

// File: rtl/sqrt_multi_step.sv
// One restoring root-bit step: trial-subtract {Q,01} from the remainder shifted by two radicand bits.
module sqrt_step #(
    parameter int unsigned RW = 8
) (
    input  logic [RW+1:0] i_a,
    input  logic [1:0]    i_bits,
    input  logic [RW-1:0] i_q,
    output logic [RW+1:0] o_a,
    output logic [RW-1:0] o_q
);

    localparam int unsigned SW = RW + 4;

    logic [SW-1:0] w_sh;
    logic [SW-1:0] w_sub;
    logic [SW-1:0] w_t;
    logic          w_ge;

    always_comb begin
        w_sh  = {i_a, i_bits};
        w_sub = SW'({i_q, 2'b01});
        w_t   = w_sh - w_sub;
        w_ge  = (w_sh >= w_sub);
        // Invariant A <= 2Q keeps both candidates within RW+2 bits.
        o_a   = w_ge ? (RW+2)'(w_t) : (RW+2)'(w_sh);
        o_q   = RW'({i_q, w_ge});
    end

endmodule

// File: rtl/sqrt_multi.sv
// Iterative square root resolving UNROLL root bits per cycle, with optional rounding and tag sideband.
module sqrt_multi
    import sqrt_multi_pkg::*;
#(
    parameter  int unsigned WIDTH  = 16,
    parameter  int unsigned FRAC   = 0,
    parameter  int unsigned UNROLL = 1,
    parameter  int unsigned ROUND  = 0,
    parameter  int unsigned TAG_W  = 4,
    localparam int unsigned RW     = calc_rw(WIDTH, FRAC)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             yumi_i,
    output logic [RW-1:0]    root_o,
    output logic [RW:0]      rem_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             exact_o
);

    localparam int unsigned C  = calc_c(RW, UNROLL);
    localparam int unsigned CW = calc_cnt_w(C);
    localparam int unsigned XW = BITS_PER_ROOT_BIT * RW;

    if ((WIDTH % 2) != 0) begin : g_bad_width
        $error("sqrt_multi: WIDTH must be even");
    end
    if ((UNROLL == 0) || ((RW % UNROLL) != 0)) begin : g_bad_unroll
        $error("sqrt_multi: UNROLL must divide the root width");
    end

    state_t           r_state;
    logic [XW-1:0]    r_x;
    logic [RW+1:0]    r_a;
    logic [RW-1:0]    r_q;
    logic [CW-1:0]    r_cnt;
    logic [TAG_W-1:0] r_tag;
    logic             r_valid;
    logic [RW-1:0]    r_root;
    logic [RW:0]      r_rem;
    logic [TAG_W-1:0] r_tag_o;
    logic             r_exact;

    logic             w_accept;
    logic [XW-1:0]    w_x_scaled;
    logic [RW:0]      w_rem;
    logic             w_up;
    logic [RW-1:0]    w_root;
    logic [RW+1:0]    w_a [UNROLL+1];
    logic [RW-1:0]    w_q [UNROLL+1];

    // Handshake: a retiring result frees the unit on the same edge.
    assign ready_o    = ~rst_i & ((r_state == S_IDLE) | ((r_state == S_DONE) & yumi_i));
    assign w_accept   = valid_i & ready_o;
    assign w_x_scaled = XW'(data_i) << (2 * FRAC);

    assign w_a[0] = r_a;
    assign w_q[0] = r_q;

    for (genvar k = 0; k < UNROLL; k++) begin : g_step
        sqrt_step #(.RW(RW)) u_step (
            .i_a    (w_a[k]),
            .i_bits (r_x[XW-1-2*k -: 2]),
            .i_q    (w_q[k]),
            .o_a    (w_a[k+1]),
            .o_q    (w_q[k+1])
        );
    end

    // Round up when the remainder exceeds Qt, unless Qt is already all-ones.
    assign w_rem  = r_a[RW:0];
    assign w_up   = (ROUND != 0) && (w_rem > {1'b0, r_q}) && !(&r_q);
    assign w_root = w_up ? (r_q + RW'(1)) : r_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_tag   <= '0;
            r_valid <= 1'b0;
            r_root  <= '0;
            r_rem   <= '0;
            r_tag_o <= '0;
            r_exact <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x     <= w_x_scaled;
                        r_a     <= '0;
                        r_q     <= '0;
                        r_cnt   <= '0;
                        r_tag   <= tag_i;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_x   <= r_x << (2 * UNROLL);
                    r_a   <= w_a[UNROLL];
                    r_q   <= w_q[UNROLL];
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(C - 1)) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_root  <= w_root;
                    r_rem   <= w_rem;
                    r_exact <= (w_rem == '0);
                    r_tag_o <= r_tag;
                    r_valid <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (yumi_i) begin
                        r_valid <= 1'b0;
                        if (w_accept) begin
                            r_x     <= w_x_scaled;
                            r_a     <= '0;
                            r_q     <= '0;
                            r_cnt   <= '0;
                            r_tag   <= tag_i;
                            r_state <= S_CALC;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign valid_o = r_valid;
    assign root_o  = r_root;
    assign rem_o   = r_rem;
    assign tag_o   = r_tag_o;
    assign exact_o = r_exact;

endmodule

// File: tb/tb_sqrt_multi.sv
// Directed scoreboard bench for sqrt_multi across truncate/round and fractional/unrolled configurations.
module tb_sqrt_multi;

    typedef struct packed {
        logic [7:0] root;
        logic [7:0] rem;
        logic       exact;
        logic [3:0] tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       v_in;
    logic [7:0] d_in;
    logic [3:0] t_in;
    logic       yumi_a;

    logic       ready_a, ready_b, ready_c, ready_d;
    logic       valid_a, valid_b, valid_c, valid_d;
    logic       yumi_b, yumi_c, yumi_d;
    logic [3:0] root_a, root_b;
    logic [4:0] rem_a, rem_b;
    logic [5:0] root_c, root_d;
    logic [6:0] rem_c, rem_d;
    logic [3:0] tag_a, tag_b, tag_c, tag_d;
    logic       exact_a, exact_b, exact_c, exact_d;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t sb_c[$];
    exp_t sb_d[$];

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

    always #5 clk = ~clk;

    assign yumi_b = valid_b;
    assign yumi_c = valid_c;
    assign yumi_d = valid_d;

    sqrt_multi #(.WIDTH(8), .FRAC(0), .UNROLL(1), .ROUND(0), .TAG_W(4)) u_a (
        .clk_i(clk), .rst_i(rst), .valid_i(v_in), .ready_o(ready_a), .data_i(d_in), .tag_i(t_in),
        .valid_o(valid_a), .yumi_i(yumi_a), .root_o(root_a), .rem_o(rem_a), .tag_o(tag_a), .exact_o(exact_a));
    sqrt_multi #(.WIDTH(8), .FRAC(0), .UNROLL(1), .ROUND(1), .TAG_W(4)) u_b (
        .clk_i(clk), .rst_i(rst), .valid_i(v_in), .ready_o(ready_b), .data_i(d_in), .tag_i(t_in),
        .valid_o(valid_b), .yumi_i(yumi_b), .root_o(root_b), .rem_o(rem_b), .tag_o(tag_b), .exact_o(exact_b));
    sqrt_multi #(.WIDTH(8), .FRAC(2), .UNROLL(2), .ROUND(0), .TAG_W(4)) u_c (
        .clk_i(clk), .rst_i(rst), .valid_i(v_in), .ready_o(ready_c), .data_i(d_in), .tag_i(t_in),
        .valid_o(valid_c), .yumi_i(yumi_c), .root_o(root_c), .rem_o(rem_c), .tag_o(tag_c), .exact_o(exact_c));
    sqrt_multi #(.WIDTH(8), .FRAC(2), .UNROLL(2), .ROUND(1), .TAG_W(4)) u_d (
        .clk_i(clk), .rst_i(rst), .valid_i(v_in), .ready_o(ready_d), .data_i(d_in), .tag_i(t_in),
        .valid_o(valid_d), .yumi_i(yumi_d), .root_o(root_d), .rem_o(rem_d), .tag_o(tag_d), .exact_o(exact_d));

    // Reference: brute-force integer root of data*4^frac, independent of the digit recurrence.
    function automatic exp_t model(input logic [7:0] data, input int frac, input int rnd, input logic [3:0] tag);
        exp_t e;
        int   x;
        int   q;
        int   r;
        int   top;
        x = int'(data) << (2 * frac);
        q = 0;
        while ((q + 1) * (q + 1) <= x) q++;
        r   = x - q * q;
        top = (1 << (4 + frac)) - 1;
        e.root = 8'(q);
        if (rnd != 0 && r > q && q < top) e.root = 8'(q + 1);
        e.rem   = 8'(r);
        e.exact = (r == 0);
        e.tag   = tag;
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
        end
    endtask

    task automatic chk_item(input string nm, input exp_t e, input logic [7:0] root, input logic [7:0] rem,
                            input logic exact, input logic [3:0] tag);
        cmp({nm, "_root"}, 32'(root), 32'(e.root));
        cmp({nm, "_rem"}, 32'(rem), 32'(e.rem));
        cmp({nm, "_exact"}, 32'(exact), 32'(e.exact));
        cmp({nm, "_tag"}, 32'(tag), 32'(e.tag));
    endtask

    // One clock: sample handshakes mid-cycle, then step past the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (valid_a && yumi_a) begin
                if (sb_a.size() == 0) cmp("a_spurious_valid", 32'(valid_a), 32'd0);
                else begin e = sb_a.pop_front(); chk_item("a", e, 8'(root_a), 8'(rem_a), exact_a, tag_a); end
            end
            if (valid_b) begin
                if (sb_b.size() == 0) cmp("b_spurious_valid", 32'(valid_b), 32'd0);
                else begin e = sb_b.pop_front(); chk_item("b", e, 8'(root_b), 8'(rem_b), exact_b, tag_b); end
            end
            if (valid_c) begin
                if (sb_c.size() == 0) cmp("c_spurious_valid", 32'(valid_c), 32'd0);
                else begin e = sb_c.pop_front(); chk_item("c", e, 8'(root_c), 8'(rem_c), exact_c, tag_c); end
            end
            if (valid_d) begin
                if (sb_d.size() == 0) cmp("d_spurious_valid", 32'(valid_d), 32'd0);
                else begin e = sb_d.pop_front(); chk_item("d", e, 8'(root_d), 8'(rem_d), exact_d, tag_d); end
            end
            if (v_in && ready_a) sb_a.push_back(model(d_in, 0, 0, t_in));
            if (v_in && ready_b) sb_b.push_back(model(d_in, 0, 1, t_in));
            if (v_in && ready_c) sb_c.push_back(model(d_in, 2, 0, t_in));
            if (v_in && ready_d) sb_d.push_back(model(d_in, 2, 1, t_in));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] t);
        v_in = 1'b1;
        d_in = d;
        t_in = t;
        #1;
        cmp("a_ready_at_send", 32'(ready_a), 32'd1);
        tick();
        v_in = 1'b0;
    endtask

    task automatic wait_a(output int l);
        l = 0;
        while (valid_a !== 1'b1 && l < 40) begin
            tick();
            l++;
        end
        cmp("a_valid_timeout", 32'(valid_a), 32'd1);
    endtask

    task automatic issue_wait(input logic [7:0] d, input logic [3:0] t);
        int l;
        send(d, t);
        wait_a(l);
        cmp("a_latency", 32'(l), 32'd5);
    endtask

    task automatic retire();
        yumi_a = 1'b1;
        tick();
        yumi_a = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        v_in   = 1'b0;
        d_in   = '0;
        t_in   = '0;
        yumi_a = 1'b0;
        repeat (2) tick();
        cmp("rst_ready", 32'(ready_a), 32'd0);
        cmp("rst_valid", 32'(valid_a), 32'd0);
        cmp("rst_root", 32'(root_a), 32'd0);
        cmp("rst_rem", 32'(rem_a), 32'd0);
        cmp("rst_tag", 32'(tag_a), 32'd0);
        cmp("rst_exact", 32'(exact_a), 32'd0);
        rst = 1'b0;
        #1;
        cmp("post_rst_ready", 32'(ready_a), 32'd1);

        // Truncated root of 200.
        issue_wait(8'd200, 4'd1);
        cmp("t200_root", 32'(root_a), 32'd14);
        cmp("t200_rem", 32'(rem_a), 32'd4);
        cmp("t200_exact", 32'(exact_a), 32'd0);
        retire();

        // Rounding cases observed on the round-to-nearest instance.
        issue_wait(8'd210, 4'd2);
        cmp("r210_root", 32'(root_b), 32'd14);
        cmp("r210_rem", 32'(rem_b), 32'd14);
        retire();
        issue_wait(8'd211, 4'd3);
        cmp("r211_root", 32'(root_b), 32'd15);
        cmp("r211_rem", 32'(rem_b), 32'd15);
        retire();
        issue_wait(8'd255, 4'd4);
        cmp("r255_root_sat", 32'(root_b), 32'd15);
        cmp("r255_rem", 32'(rem_b), 32'd30);
        retire();
        issue_wait(8'd0, 4'd5);
        cmp("r0_root", 32'(root_b), 32'd0);
        cmp("r0_exact", 32'(exact_b), 32'd1);
        retire();

        // Fractional, two bits per cycle.
        send(8'd2, 4'd6);
        lat = 0;
        while (valid_c !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        cmp("c_latency", 32'(lat), 32'd4);
        cmp("c2_root", 32'(root_c), 32'd5);
        cmp("c2_rem", 32'(rem_c), 32'd7);
        cmp("d2_root", 32'(root_d), 32'd6);
        wait_a(lat);
        retire();

        // Back-to-back: retire and accept on the same edge.
        v_in = 1'b1;
        d_in = 8'd16;
        t_in = 4'd3;
        tick();
        d_in = 8'd49;
        t_in = 4'd5;
        wait_a(lat);
        cmp("b2b_first_latency", 32'(lat), 32'd5);
        yumi_a = 1'b1;
        #1;
        cmp("b2b_ready_on_yumi", 32'(ready_a), 32'd1);
        cmp("b2b_first_root", 32'(root_a), 32'd4);
        cmp("b2b_first_tag", 32'(tag_a), 32'd3);
        tick();
        yumi_a = 1'b0;
        wait_a(lat);
        cmp("b2b_second_latency", 32'(lat), 32'd5);
        cmp("b2b_second_root", 32'(root_a), 32'd7);
        cmp("b2b_second_tag", 32'(tag_a), 32'd5);
        cmp("b2b_second_exact", 32'(exact_a), 32'd1);
        v_in = 1'b0;
        retire();

        // Backpressure: result held while yumi is low.
        issue_wait(8'd100, 4'd7);
        for (int i = 0; i < 10; i++) begin
            tick();
            cmp("bp_valid", 32'(valid_a), 32'd1);
            cmp("bp_ready", 32'(ready_a), 32'd0);
            cmp("bp_root", 32'(root_a), 32'd10);
            cmp("bp_rem", 32'(rem_a), 32'd0);
            cmp("bp_tag", 32'(tag_a), 32'd7);
        end
        retire();
        cmp("bp_idle_valid", 32'(valid_a), 32'd0);
        cmp("bp_idle_ready", 32'(ready_a), 32'd1);

        // Reset in the middle of a calculation.
        send(8'd200, 4'd2);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        cmp("mid_rst_valid", 32'(valid_a), 32'd0);
        cmp("mid_rst_root", 32'(root_a), 32'd0);
        cmp("mid_rst_rem", 32'(rem_a), 32'd0);
        cmp("mid_rst_tag", 32'(tag_a), 32'd0);
        cmp("mid_rst_ready", 32'(ready_a), 32'd0);
        sb_a.delete();
        sb_b.delete();
        sb_c.delete();
        sb_d.delete();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            cmp("post_abort_no_valid", 32'(valid_a), 32'd0);
        end
        issue_wait(8'd144, 4'd9);
        cmp("f144_root", 32'(root_a), 32'd12);
        cmp("f144_rem", 32'(rem_a), 32'd0);
        cmp("f144_exact", 32'(exact_a), 32'd1);
        retire();

        repeat (8) tick();
        cmp("a_sb_left", 32'(sb_a.size()), 32'd0);
        cmp("b_sb_left", 32'(sb_b.size()), 32'd0);
        cmp("c_sb_left", 32'(sb_c.size()), 32'd0);
        cmp("d_sb_left", 32'(sb_d.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
